// File: rtl/eight_bit_add_multi_pkg.sv
// Shared constants for the add/multiply datapath slice.
package eight_bit_add_multi_pkg;
    localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/eight_bit_add_multi_if.sv
// Operand/result bundle for the add/multiply block; master drives operands.
interface eight_bit_add_multi_if
    import eight_bit_add_multi_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [WIDTH-1:0] out;

    modport master (output a, b, input sum, cout, out);
    modport slave  (input a, b, output sum, cout, out);
endinterface

// File: rtl/eight_bit_ripple_add.sv
// Ripple-carry adder built from a chain of full-adder bit slices.
module eight_bit_ripple_add
    import eight_bit_add_multi_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[WIDTH];
endmodule

// File: rtl/eight_bit_add_multi.sv
// Registered unsigned add (with carry) and truncated multiply of a and b.
module eight_bit_add_multi
    import eight_bit_add_multi_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] out
);
    logic [WIDTH-1:0] add_s;
    logic             add_c;

    eight_bit_ripple_add #(.WIDTH(WIDTH)) u_add (
        .a    (a),
        .b    (b),
        .cin  (1'b0),
        .sum  (add_s),
        .cout (add_c)
    );

    // Partial products are already truncated to WIDTH bits, so the
    // accumulation chain only ever carries the low half of the product.
    logic [WIDTH-1:0][WIDTH-1:0] pp;
    logic [WIDTH-1:0][WIDTH-1:0] acc;
    logic [WIDTH-1:1]            mul_c_unused;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pp
        assign pp[i] = (b & {WIDTH{a[i]}}) << i;
    end

    assign acc[0] = pp[0];

    for (genvar i = 1; i < WIDTH; i++) begin : g_acc
        eight_bit_ripple_add #(.WIDTH(WIDTH)) u_stage (
            .a    (acc[i-1]),
            .b    (pp[i]),
            .cin  (1'b0),
            .sum  (acc[i]),
            .cout (mul_c_unused[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
            out  <= '0;
        end else begin
            sum  <= add_s;
            cout <= add_c;
            out  <= acc[WIDTH-1];
        end
    end
endmodule

// File: tb/tb_eight_bit_add_multi.sv
// Scoreboard bench for eight_bit_add_multi: directed corners plus random back-to-back pairs.
module tb_eight_bit_add_multi;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    eight_bit_add_multi_if #(.WIDTH(8)) bus ();

    eight_bit_add_multi #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (bus.a),
        .b    (bus.b),
        .sum  (bus.sum),
        .cout (bus.cout),
        .out  (bus.out)
    );

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic [7:0] out;
    } res_t;

    res_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Drive one operand pair, push its expected result, advance one edge.
    task automatic apply(input logic [7:0] av, input logic [7:0] bv, input logic r);
        logic [8:0]  s9;
        logic [15:0] p;
        res_t        e;
        bus.a = av;
        bus.b = bv;
        rst   = r;
        s9 = {1'b0, av} + {1'b0, bv};
        p  = 16'(av) * 16'(bv);
        if (r) e = '0;
        else   e = '{sum: s9[7:0], cout: s9[8], out: p[7:0]};
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        res_t e, got;
        logic [7:0] ops [2] = '{8'd200, 8'd255};
        for (int i = 0; i < 2; i++) begin
            apply(ops[i], ops[i], 1'b1);
            e   = sb.pop_front();
            got = '{sum: bus.sum, cout: bus.cout, out: bus.out};
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL reset[%0d]: got sum=%0d cout=%0d out=%0d, required sum=%0d cout=%0d out=%0d",
                         i, got.sum, got.cout, got.out, e.sum, e.cout, e.out);
            end
        end
    endtask

    task automatic test_basic();
        res_t e, got;
        apply(8'd13, 8'd11, 1'b0);
        e   = sb.pop_front();
        got = '{sum: bus.sum, cout: bus.cout, out: bus.out};
        n_cmp++;
        if (got !== e || got !== '{sum: 8'd24, cout: 1'b0, out: 8'd143}) begin
            n_err++;
            $display("FAIL basic_13x11: got sum=%0d cout=%0d out=%0d, required sum=24 cout=0 out=143",
                     got.sum, got.cout, got.out);
        end
        // New operands must not ripple through before the next edge.
        bus.a = 8'd1;
        bus.b = 8'd3;
        #3;
        got = '{sum: bus.sum, cout: bus.cout, out: bus.out};
        n_cmp++;
        if (got !== '{sum: 8'd24, cout: 1'b0, out: 8'd143}) begin
            n_err++;
            $display("FAIL hold: got sum=%0d cout=%0d out=%0d, required sum=24 cout=0 out=143",
                     got.sum, got.cout, got.out);
        end
        @(negedge clk);
        apply(8'd1, 8'd3, 1'b0);
        e   = sb.pop_front();
        got = '{sum: bus.sum, cout: bus.cout, out: bus.out};
        n_cmp++;
        if (got !== e || got !== '{sum: 8'd4, cout: 1'b0, out: 8'd3}) begin
            n_err++;
            $display("FAIL basic_1x3: got sum=%0d cout=%0d out=%0d, required sum=4 cout=0 out=3",
                     got.sum, got.cout, got.out);
        end
    endtask

    task automatic test_wrap();
        res_t e, got;
        logic [7:0] av [4] = '{8'd255, 8'd16, 8'd255, 8'd128};
        logic [7:0] bv [4] = '{8'd1,   8'd16, 8'd255, 8'd128};
        res_t       rq [4] = '{'{sum: 8'd0,   cout: 1'b1, out: 8'd255},
                               '{sum: 8'd32,  cout: 1'b0, out: 8'd0},
                               '{sum: 8'd254, cout: 1'b1, out: 8'd1},
                               '{sum: 8'd0,   cout: 1'b1, out: 8'd0}};
        for (int i = 0; i < 4; i++) begin
            apply(av[i], bv[i], 1'b0);
            e   = sb.pop_front();
            got = '{sum: bus.sum, cout: bus.cout, out: bus.out};
            n_cmp++;
            if (got !== e || got !== rq[i]) begin
                n_err++;
                $display("FAIL wrap_%0dx%0d: got sum=%0d cout=%0d out=%0d, required sum=%0d cout=%0d out=%0d",
                         av[i], bv[i], got.sum, got.cout, got.out, rq[i].sum, rq[i].cout, rq[i].out);
            end
        end
    endtask

    task automatic test_reset_priority();
        res_t e, got;
        res_t rq [2] = '{'{sum: 8'd0,  cout: 1'b0, out: 8'd0},
                         '{sum: 8'd44, cout: 1'b1, out: 8'd32}};
        for (int i = 0; i < 2; i++) begin
            apply(8'd200, 8'd100, (i == 0));
            e   = sb.pop_front();
            got = '{sum: bus.sum, cout: bus.cout, out: bus.out};
            n_cmp++;
            if (got !== e || got !== rq[i]) begin
                n_err++;
                $display("FAIL rst_prio[%0d]: got sum=%0d cout=%0d out=%0d, required sum=%0d cout=%0d out=%0d",
                         i, got.sum, got.cout, got.out, rq[i].sum, rq[i].cout, rq[i].out);
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t e, got;
        int   errs = 0;
        for (int i = 0; i < 10000; i++) begin
            apply(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL b2b_empty[%0d]: scoreboard empty, required one pending entry", i);
            end else begin
                e   = sb.pop_front();
                got = '{sum: bus.sum, cout: bus.cout, out: bus.out};
                if (got !== e) begin
                    n_err++;
                    errs++;
                    if (errs <= 10)
                        $display("FAIL b2b[%0d] a=%0d b=%0d: got sum=%0d cout=%0d out=%0d, required sum=%0d cout=%0d out=%0d",
                                 i, bus.a, bus.b, got.sum, got.cout, got.out, e.sum, e.cout, e.out);
                end
            end
        end
    endtask

    initial begin
        bus.a = '0;
        bus.b = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_wrap();
        test_reset_priority();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
